// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch stage ahead of the decoder. Owns the PC,
//             issues one instruction-memory read at a time over a
//             req/ready + rvalid handshake, and presents a registered
//             inst/pc_addr pair with a valid flag. Honours downstream stall
//             and a single-cycle redirect, dropping stale responses.
//  Options  : FETCH_MISALIGN_CHECK_EN - trap misaligned redirect targets
//             into a sticky fetch_fault state instead of forcing alignment.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc_addr,
    output logic        fetch_fault
);

    localparam logic [1:0] c_S_REQ   = 2'd0;
    localparam logic [1:0] c_S_WAIT  = 2'd1;
    localparam logic [1:0] c_S_HOLD  = 2'd2;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [1:0] c_S_FAULT = 2'd3;
`endif

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_drop;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_pc_addr;

    logic        w_accept;
    logic        w_waiting;
    logic [31:0] w_target;
    logic        w_redir_drop;
    logic [1:0]  w_redir_state;

    // A request exists only in S_REQ; held low while reset is asserted.
    assign imem_req  = rst_n & (r_state == c_S_REQ);
    assign imem_addr = r_pc;
    assign w_accept  = (r_state == c_S_REQ) & imem_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_fault;
    logic w_misaligned;

    // The PC is loaded verbatim; misalignment is trapped, not corrected.
    assign w_target     = redirect_pc;
    assign w_misaligned = |redirect_pc[1:0];
    // S_FAULT still owes a response when entered with a stale one in flight.
    assign w_waiting    = (r_state == c_S_WAIT) | ((r_state == c_S_FAULT) & r_drop);
    assign fetch_fault  = r_fault;
`else
    // Low address bits are discarded so fetch is always word aligned.
    assign w_target     = redirect_pc & 32'hFFFF_FFFC;
    assign w_waiting    = (r_state == c_S_WAIT);
    assign fetch_fault  = 1'b0;
`endif

    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign pc_addr    = r_pc_addr;

    // Redirect destination: a response is still owed if one was launched this
    // cycle or is outstanding without arriving in this same cycle.
    always_comb begin
        w_redir_drop  = w_accept | (w_waiting & ~imem_rvalid);
        w_redir_state = w_redir_drop ? c_S_WAIT : c_S_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (w_misaligned) begin
            w_redir_state = c_S_FAULT;
        end
`endif
    end

    // Fetch FSM, PC and output register; redirect overrides everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_S_REQ;
            r_pc         <= RESET_PC;
            r_drop       <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'h0;
            r_pc_addr    <= 32'h0;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_fault      <= 1'b0;
`endif
        end else if (redirect_valid) begin
            r_pc         <= w_target;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'h0;
            r_state      <= w_redir_state;
            r_drop       <= w_redir_drop;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_fault      <= w_misaligned;
`endif
        end else begin
            case (r_state)
                c_S_REQ: begin
                    if (w_accept) begin
                        r_state <= c_S_WAIT;
                    end
                end
                c_S_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_drop) begin
                            // Stale word from before a redirect: discard it.
                            r_drop  <= 1'b0;
                            r_state <= c_S_REQ;
                        end else begin
                            r_inst_valid <= 1'b1;
                            r_inst       <= imem_rdata;
                            r_pc_addr    <= r_pc;
                            r_pc         <= r_pc + 32'd4;
                            r_state      <= c_S_HOLD;
                        end
                    end
                end
                c_S_HOLD: begin
                    if (r_inst_valid & ~stall) begin
                        r_inst_valid <= 1'b0;
                        r_inst       <= 32'h0;
                        r_state      <= c_S_REQ;
                    end
                end
`ifdef FETCH_MISALIGN_CHECK_EN
                c_S_FAULT: begin
                    // Parked until an aligned redirect; swallow any stale word.
                    if (imem_rvalid) begin
                        r_drop <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= c_S_REQ;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage: directed scenarios plus a
//             randomized run against a transaction-level fetch model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc_addr;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;

    // Memory model state
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_cnt  = 0;
    int          mem_lat  = 0;

    // What happened on the edge just taken
    bit          last_acc = 1'b0;
    logic [31:0] last_acc_addr = 32'h0;
    bit          last_stall = 1'b0;
    bit          last_redir = 1'b0;

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .pc_addr        (pc_addr),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    // Drive one cycle of inputs (memory answers from its own model), then
    // advance to the next falling edge where outputs are sampled.
    task automatic tick(input bit rdy, input bit stl, input bit rdr, input logic [31:0] tgt);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_of(mem_addr);
                mem_busy    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        imem_ready     = rdy;
        stall          = stl;
        redirect_valid = rdr;
        redirect_pc    = tgt;
        last_acc       = imem_req && rdy;
        last_acc_addr  = imem_addr;
        if (last_acc) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = mem_lat;
        end
        last_stall = stl;
        last_redir = rdr;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick(1'b1, 1'b0, 1'b0, 32'h0);
        total++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 ||
            pc_addr !== 32'h0 || fetch_fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: req=%b iv=%b inst=%h pca=%h fault=%b want all zero",
                     imem_req, inst_valid, inst, pc_addr, fetch_fault);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            bad++;
            $display("FAIL reset_first_req: req=%b addr=%h want 1 00000100", imem_req, imem_addr);
        end
    endtask

    task automatic test_straight_line();
        logic [31:0] a;
        mem_lat = 0;
        for (int k = 0; k < 3; k++) begin
            a = 32'h100 + 32'(4 * k);
            total++;
            if (imem_req !== 1'b1 || imem_addr !== a) begin
                bad++;
                $display("FAIL line_req: req=%b addr=%h want 1 %h", imem_req, imem_addr, a);
            end
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            total++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                bad++;
                $display("FAIL line_wait: req=%b iv=%b want 0 0", imem_req, inst_valid);
            end
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            total++;
            if (inst_valid !== 1'b1 || inst !== word_of(a) || pc_addr !== a) begin
                bad++;
                $display("FAIL line_out: iv=%b inst=%h pca=%h want 1 %h %h",
                         inst_valid, inst, pc_addr, word_of(a), a);
            end
            tick(1'b1, 1'b0, 1'b0, 32'h0);
        end
    endtask

    task automatic test_stall();
        logic [31:0] hold_inst;
        logic [31:0] hold_pca;
        mem_lat = 0;
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        hold_inst = word_of(32'h10C);
        hold_pca  = 32'h10C;
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            total++;
            if (inst_valid !== 1'b1 || inst !== hold_inst || pc_addr !== hold_pca || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold: iv=%b inst=%h pca=%h req=%b want 1 %h %h 0",
                         inst_valid, inst, pc_addr, imem_req, hold_inst, hold_pca);
            end
        end
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        total++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h110) begin
            bad++;
            $display("FAIL stall_release: iv=%b req=%b addr=%h want 0 1 00000110",
                     inst_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        bit seen;
        tick(1'b0, 1'b0, 1'b1, 32'h200);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200 || inst_valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_req_next: req=%b addr=%h iv=%b want 1 00000200 0",
                     imem_req, imem_addr, inst_valid);
        end
        mem_lat = 2;
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 32'h400);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            total++;
            if (inst_valid !== 1'b0) begin
                bad++;
                $display("FAIL redir_wait_stale: iv=%b inst=%h want 0", inst_valid, inst);
            end
            if (imem_req === 1'b1) seen = 1'b1;
            else tick(1'b0, 1'b0, 1'b0, 32'h0);
        end
        total++;
        if (!seen || imem_addr !== 32'h400) begin
            bad++;
            $display("FAIL redir_wait_next: seen=%b addr=%h want 1 00000400", seen, imem_addr);
        end
    endtask

    task automatic test_redirect_accept();
        mem_lat = 0;
        tick(1'b1, 1'b0, 1'b1, 32'h500);
        total++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL redir_acc_wait: iv=%b req=%b want 0 0", inst_valid, imem_req);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        total++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h500) begin
            bad++;
            $display("FAIL redir_acc_next: iv=%b req=%b addr=%h want 0 1 00000500",
                     inst_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_rvalid();
        mem_lat = 1;
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 32'h600);
        total++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h600) begin
            bad++;
            $display("FAIL redir_rv_next: iv=%b req=%b addr=%h want 0 1 00000600",
                     inst_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_hold();
        mem_lat = 0;
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        total++;
        if (inst_valid !== 1'b1 || pc_addr !== 32'h600 || inst !== word_of(32'h600)) begin
            bad++;
            $display("FAIL hold_fill: iv=%b pca=%h inst=%h want 1 00000600 %h",
                     inst_valid, pc_addr, inst, word_of(32'h600));
        end
        tick(1'b0, 1'b1, 1'b1, 32'h700);
        total++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h700) begin
            bad++;
            $display("FAIL hold_redir: iv=%b inst=%h req=%b addr=%h want 0 0 1 00000700",
                     inst_valid, inst, imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap_and_reset();
        tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        mem_lat = 0;
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        total++;
        if (inst_valid !== 1'b1 || pc_addr !== 32'hFFFF_FFFC || inst !== word_of(32'hFFFF_FFFC)) begin
            bad++;
            $display("FAIL wrap_out: iv=%b pca=%h inst=%h want 1 fffffffc %h",
                     inst_valid, pc_addr, inst, word_of(32'hFFFF_FFFC));
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL wrap_next: req=%b addr=%h want 1 00000000", imem_req, imem_addr);
        end
        mem_lat = 3;
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || pc_addr !== 32'h0 || fetch_fault !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: req=%b iv=%b inst=%h pca=%h fault=%b want all zero",
                     imem_req, inst_valid, inst, pc_addr, fetch_fault);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
                bad++;
                $display("FAIL late_rvalid: iv=%b req=%b addr=%h want 0 1 00000100",
                         inst_valid, imem_req, imem_addr);
            end
            tick(1'b0, 1'b0, 1'b0, 32'h0);
        end
    endtask

    task automatic test_misalign();
        tick(1'b0, 1'b0, 1'b1, 32'h302);
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int k = 0; k < 4; k++) begin
            total++;
            if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL misalign_trap: fault=%b req=%b want 1 0", fetch_fault, imem_req);
            end
            tick(1'b1, 1'b0, 1'b0, 32'h0);
        end
        tick(1'b0, 1'b0, 1'b1, 32'h300);
`endif
        total++;
        if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            bad++;
            $display("FAIL misalign_resume: fault=%b req=%b addr=%h want 0 1 00000300",
                     fetch_fault, imem_req, imem_addr);
        end
    endtask

    // Randomized run. Model: each non-stale accepted request yields exactly one
    // delivered instruction for that address; fetch order is sequential by 4
    // except that a redirect restarts it at the target.
    task automatic test_random();
        bit          live;
        logic [31:0] live_addr;
        logic [31:0] exp_req;
        int          deliveries;
        live = 1'b0;
        live_addr = 32'h0;
        exp_req = 32'h0;
        deliveries = 0;
        for (int i = 0; i < 3000; i++) begin
            bit          rdy;
            bit          stl;
            bit          rdr;
            bit          prev_iv;
            logic [31:0] prev_inst;
            logic [31:0] prev_pca;
            logic [31:0] tgt;
            rdy = ($urandom_range(0, 99) < 60);
            stl = ($urandom_range(0, 99) < 30);
            rdr = (i == 0) || ($urandom_range(0, 99) < 6);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            mem_lat   = $urandom_range(0, 3);
            prev_iv   = inst_valid;
            prev_inst = inst;
            prev_pca  = pc_addr;
            tick(rdy, stl, rdr, tgt);

            if (last_acc && !last_redir) begin
                total++;
                if (last_acc_addr !== exp_req) begin
                    bad++;
                    $display("FAIL rnd_req_addr: got %h want %h", last_acc_addr, exp_req);
                end
                live      = 1'b1;
                live_addr = last_acc_addr;
                exp_req   = last_acc_addr + 32'd4;
            end
            if (last_redir) begin
                exp_req = tgt;
                live    = 1'b0;
                total++;
                if (inst_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_redir_clear: iv=%b want 0", inst_valid);
                end
            end
            if (!inst_valid) begin
                total++;
                if (inst !== 32'h0) begin
                    bad++;
                    $display("FAIL rnd_inst_zero: inst=%h want 0", inst);
                end
            end else begin
                total++;
                if (imem_req !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_single_out: req=%b want 0", imem_req);
                end
            end
            if (prev_iv && !last_redir) begin
                total++;
                if (last_stall && (inst_valid !== 1'b1 || inst !== prev_inst || pc_addr !== prev_pca)) begin
                    bad++;
                    $display("FAIL rnd_stall_hold: iv=%b inst=%h pca=%h want 1 %h %h",
                             inst_valid, inst, pc_addr, prev_inst, prev_pca);
                end else if (!last_stall && inst_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_consume: iv=%b want 0", inst_valid);
                end
            end
            if (inst_valid && !prev_iv) begin
                deliveries++;
                total++;
                if (!live || pc_addr !== live_addr || inst !== word_of(live_addr)) begin
                    bad++;
                    $display("FAIL rnd_deliver: live=%b pca=%h inst=%h want 1 %h %h",
                             live, pc_addr, inst, live_addr, word_of(live_addr));
                end
                live = 1'b0;
            end
        end
        total++;
        if (deliveries < 100) begin
            bad++;
            $display("FAIL rnd_progress: deliveries=%0d want >=100", deliveries);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_straight_line();
        test_stall();
        test_redirect_wait();
        test_redirect_accept();
        test_redirect_rvalid();
        test_redirect_hold();
        test_wrap_and_reset();
        test_misalign();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, want finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
